// File: rtl/updn_button_ctrl.sv
// Two-button up/down command generator: sync, debounce and arbitration into clean commands.
// Define UPDN_PULSE_EN to turn the held-button level into auto-repeat pulses every RPT_CYCLES cycles.
//
//   state | meaning
//   IDLE  | no debounced button owns the output
//   UP    | up button owns the output, down ignored until up releases
//   DOWN  | down button owns the output, up ignored until down releases
//   LOCK  | both pressed together, commands suppressed until both release
module updn_button_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned RPT_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic conflict
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1 || DEB_CYCLES > 65535 || RPT_CYCLES < 2 || RPT_CYCLES > 65535) begin : g_bad_cfg
        $error("updn_button_ctrl: DEB_CYCLES or RPT_CYCLES out of range");
    end

    // bit 0 = up button, bit 1 = down button
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] db;
    logic [1:0] state;
    logic [1:0] state_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= {btn_down_raw, btn_up_raw};
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic [15:0] deb_cnt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                deb_cnt <= 16'd0;
                db[i]   <= 1'b0;
            end else if (sync_b[i] == db[i]) begin
                deb_cnt <= 16'd0;
            end else if (deb_cnt == DEB_LAST) begin
                db[i]   <= sync_b[i];
                deb_cnt <= 16'd0;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (db[0] && db[1])   state_nxt = S_LOCK;
                else if (db[0])       state_nxt = S_UP;
                else if (db[1])       state_nxt = S_DOWN;
            end
            S_UP:    if (!db[0])           state_nxt = S_IDLE;
            S_DOWN:  if (!db[1])           state_nxt = S_IDLE;
            default: if (!db[0] && !db[1]) state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    assign conflict = (state == S_LOCK);

`ifdef UPDN_PULSE_EN
    localparam logic [15:0] RPT_LAST = 16'(RPT_CYCLES - 1);

    logic [15:0] rpt_cnt;

    // UP/DOWN are only ever entered from IDLE, where the count is held at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt <= 16'd0;
        end else if (state == S_UP || state == S_DOWN) begin
            rpt_cnt <= (rpt_cnt == RPT_LAST) ? 16'd0 : rpt_cnt + 16'd1;
        end else begin
            rpt_cnt <= 16'd0;
        end
    end

    assign up   = (state == S_UP)   && (rpt_cnt == 16'd0);
    assign down = (state == S_DOWN) && (rpt_cnt == 16'd0);
`else
    assign up   = (state == S_UP);
    assign down = (state == S_DOWN);
`endif

endmodule
